mdu_issue_ctrl: RTL and testbench

//  Issue/hazard controller for the E-stage multiply/divide unit. Decides when an E-stage MDU op
//  may start, drives Start/MDUOp into the MDU, shadows its busy window with its own latency

---
 rtl/mdu_issue_ctrl_pkg.sv | 34 +++
 rtl/mdu_issue_ctrl_lat_counter.sv | 28 ++
 rtl/mdu_issue_ctrl.sv | 84 ++++++++
 tb/tb_mdu_issue_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue controller: op codes, latency defaults,
// FSM state encoding and op-class helpers.
package mdu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_none  = 3'd0,
    MDU_mult  = 3'd1,
    MDU_multu = 3'd2,
    MDU_div   = 3'd3,
    MDU_divu  = 3'd4,
    MDU_mthi  = 3'd5,
    MDU_mtlo  = 3'd6
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W_DEF       = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // LONG ops occupy the MDU for several cycles and need a Start pulse.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MDU_mult) || (op == MDU_multu) ||
           (op == MDU_div)  || (op == MDU_divu);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MDU_mult) || (op == MDU_multu);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_lat_counter.sv
// Latency counter shadowing the MDU busy window: load, hold or decrement,
// with a flag marking the final busy cycle.
module mdu_lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue/hazard controller for the E-stage multiply/divide unit: starts MDU ops,
// mirrors the MDU busy window and stalls D-stage MDU/HI-LO instructions.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        E_Valid,
  input  logic [2:0]  E_MDUOp,
  input  logic [2:0]  D_MDUOp,
  input  logic        D_UseHILO,
  output logic        Start,
  output logic [2:0]  MDUOp,
  output logic        Busy,
  output logic        Stall_D,
  output logic        ProtoErr,
  output logic [15:0] StallCnt
);

  mdu_state_e       r_state;
  logic             r_proto_err;
  logic [15:0]      r_stall_cnt;

  logic             w_issue_ok;
  logic             w_e_long;
  logic             w_d_hazard;
  logic             w_dec;
  logic             w_cnt_one;
  logic [CNT_W-1:0] w_load_val;

  assign w_issue_ok = E_Valid && !Req;
  assign w_e_long   = is_long_op(E_MDUOp);
  assign w_d_hazard = (D_MDUOp != MDU_none) || D_UseHILO;

  assign Start    = w_issue_ok && w_e_long && (r_state == ST_IDLE);
  assign MDUOp    = w_issue_ok ? E_MDUOp : 3'(MDU_none);
  assign Busy     = (r_state == ST_RUN);
  assign Stall_D  = w_d_hazard && (Busy || Start);
  assign ProtoErr = r_proto_err;
  assign StallCnt = r_stall_cnt;

  assign w_load_val = is_mult_op(E_MDUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
  // The MDU freezes while Req is high, so the shadow counter must too.
  assign w_dec      = (r_state == ST_RUN) && !Req;

  mdu_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .rst        (reset),
    .i_load     (Start),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_is_one   (w_cnt_one)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_proto_err <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (Start) r_state <= ST_RUN;
        ST_RUN:  if (w_dec && w_cnt_one) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_issue_ok && w_e_long && (r_state == ST_RUN)) begin
        r_proto_err <= 1'b1;
      end

      if (Stall_D && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: a cycle model pushes expected outputs
// into a scoreboard queue; scenario tasks add their own targeted checks.
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic        E_Valid;
  logic [2:0]  E_MDUOp;
  logic [2:0]  D_MDUOp;
  logic        D_UseHILO;
  logic        Start;
  logic [2:0]  MDUOp;
  logic        Busy;
  logic        Stall_D;
  logic        ProtoErr;
  logic [15:0] StallCnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start;
    logic [2:0]  op;
    logic        busy;
    logic        stall;
    logic        perr;
    logic [15:0] scnt;
  } exp_t;

  exp_t sb_q[$];

  bit          m_busy;
  int unsigned m_cnt;
  bit          m_perr;
  int unsigned m_scnt;

  mdu_issue_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Req       (Req),
    .E_Valid   (E_Valid),
    .E_MDUOp   (E_MDUOp),
    .D_MDUOp   (D_MDUOp),
    .D_UseHILO (D_UseHILO),
    .Start     (Start),
    .MDUOp     (MDUOp),
    .Busy      (Busy),
    .Stall_D   (Stall_D),
    .ProtoErr  (ProtoErr),
    .StallCnt  (StallCnt)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive inputs, predict outputs, compare at the falling edge.
  task automatic step(input logic req, input logic ev, input logic [2:0] eop,
                      input logic [2:0] dop, input logic hilo);
    exp_t e;
    exp_t g;
    logic lng;
    Req = req; E_Valid = ev; E_MDUOp = eop; D_MDUOp = dop; D_UseHILO = hilo;
    lng     = (eop == 3'd1) || (eop == 3'd2) || (eop == 3'd3) || (eop == 3'd4);
    e.op    = (ev && !req) ? eop : 3'd0;
    e.start = ev && !req && lng && !m_busy;
    e.busy  = m_busy;
    e.stall = ((dop != 3'd0) || hilo) && (m_busy || e.start);
    e.perr  = m_perr;
    e.scnt  = m_scnt[15:0];
    sb_q.push_back(e);
    if (ev && !req && lng && m_busy) m_perr = 1'b1;
    if (e.stall && m_scnt < 32'hFFFF) m_scnt++;
    if (e.start) begin
      m_busy = 1'b1;
      m_cnt  = ((eop == 3'd1) || (eop == 3'd2)) ? 5 : 10;
    end else if (m_busy && !req) begin
      if (m_cnt == 1) m_busy = 1'b0;
      m_cnt--;
    end
    @(negedge clk);
    g = sb_q.pop_front();
    checks++; if (Start !== g.start) begin errors++;
      $display("FAIL sb_start t=%0t: got %b expected %b", $time, Start, g.start); end
    checks++; if (MDUOp !== g.op) begin errors++;
      $display("FAIL sb_mduop t=%0t: got %0d expected %0d", $time, MDUOp, g.op); end
    checks++; if (Busy !== g.busy) begin errors++;
      $display("FAIL sb_busy t=%0t: got %b expected %b", $time, Busy, g.busy); end
    checks++; if (Stall_D !== g.stall) begin errors++;
      $display("FAIL sb_stall t=%0t: got %b expected %b", $time, Stall_D, g.stall); end
    checks++; if (ProtoErr !== g.perr) begin errors++;
      $display("FAIL sb_protoerr t=%0t: got %b expected %b", $time, ProtoErr, g.perr); end
    checks++; if (StallCnt !== g.scnt) begin errors++;
      $display("FAIL sb_stallcnt t=%0t: got %0d expected %0d", $time, StallCnt, g.scnt); end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    Req = 1'b0; E_Valid = 1'b0; E_MDUOp = 3'd0; D_MDUOp = 3'd0; D_UseHILO = 1'b0;
  endtask

  // Called at posedge+1; raises reset mid-cycle, away from any clock edge.
  task automatic assert_reset();
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    m_busy = 1'b0; m_cnt = 0; m_perr = 1'b0; m_scnt = 0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    m_busy = 1'b0; m_cnt = 0; m_perr = 1'b0; m_scnt = 0;
    @(posedge clk); #1;
    checks++; if (Busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (ProtoErr !== 1'b0) begin errors++;
      $display("FAIL reset_protoerr: got %b expected 0", ProtoErr); end
    checks++; if (StallCnt !== 16'd0) begin errors++;
      $display("FAIL reset_stallcnt: got %0d expected 0", StallCnt); end
    checks++; if (Start !== 1'b0 || MDUOp !== 3'd0 || Stall_D !== 1'b0) begin errors++;
      $display("FAIL reset_comb: got start=%b op=%0d stall=%b expected 0/0/0", Start, MDUOp, Stall_D); end
    release_reset();
  endtask

  task automatic test_mult();
    int n;
    step(1'b0, 1'b1, 3'(MDU_mult), 3'(MDU_none), 1'b0);
    n = 0;
    while (Busy === 1'b1 && n < 20) begin
      n++;
      step(1'b0, 1'b0, 3'(MDU_none), 3'(MDU_none), 1'b0);
    end
    checks++; if (n != 5) begin errors++;
      $display("FAIL mult_busy_len: got %0d cycles expected 5", n); end
  endtask

  task automatic test_divu_mflo();
    int n;
    logic [15:0] s0;
    s0 = StallCnt;
    step(1'b0, 1'b1, 3'(MDU_divu), 3'(MDU_none), 1'b1);
    n = 0;
    while (Busy === 1'b1 && n < 30) begin
      n++;
      step(1'b0, 1'b0, 3'(MDU_none), 3'(MDU_none), 1'b1);
    end
    checks++; if (n != 10) begin errors++;
      $display("FAIL divu_busy_len: got %0d cycles expected 10", n); end
    step(1'b0, 1'b0, 3'(MDU_none), 3'(MDU_none), 1'b1);
    checks++; if (StallCnt - s0 !== 16'd11) begin errors++;
      $display("FAIL divu_stallcnt: got %0d expected 11", StallCnt - s0); end
    step(1'b0, 1'b1, 3'(MDU_none), 3'(MDU_none), 1'b0);
  endtask

  task automatic test_req_mid_run();
    int n;
    step(1'b0, 1'b1, 3'(MDU_div), 3'(MDU_none), 1'b0);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      step((n >= 3 && n <= 5), 1'b0, 3'(MDU_none), 3'(MDU_none), 1'b0);
    end
    checks++; if (n != 13) begin errors++;
      $display("FAIL req_mid_busy_len: got %0d cycles expected 13", n); end
  endtask

  task automatic test_req_issue();
    step(1'b1, 1'b1, 3'(MDU_mult), 3'(MDU_none), 1'b0);
    checks++; if (Busy !== 1'b0) begin errors++;
      $display("FAIL req_issue_busy: got %b expected 0", Busy); end
    step(1'b1, 1'b1, 3'(MDU_mthi), 3'(MDU_none), 1'b0);
    step(1'b0, 1'b1, 3'(MDU_mtlo), 3'(MDU_none), 1'b0);
    checks++; if (Busy !== 1'b0) begin errors++;
      $display("FAIL short_op_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_proto_err();
    int n;
    step(1'b0, 1'b1, 3'(MDU_mult), 3'(MDU_none), 1'b0);
    step(1'b0, 1'b1, 3'(MDU_mult), 3'(MDU_none), 1'b0);
    checks++; if (ProtoErr !== 1'b1) begin errors++;
      $display("FAIL proto_set: got %b expected 1", ProtoErr); end
    step(1'b0, 1'b0, 3'(MDU_none), 3'(MDU_mthi), 1'b0);
    n = 0;
    while (Busy === 1'b1 && n < 20) begin
      n++;
      step(1'b0, 1'b1, 3'(MDU_none), 3'(MDU_none), 1'b0);
    end
    checks++; if (ProtoErr !== 1'b1) begin errors++;
      $display("FAIL proto_sticky: got %b expected 1", ProtoErr); end
  endtask

  task automatic test_async_reset();
    int n;
    step(1'b0, 1'b1, 3'(MDU_mult), 3'(MDU_none), 1'b0);
    step(1'b0, 1'b0, 3'(MDU_none), 3'(MDU_none), 1'b0);
    step(1'b0, 1'b0, 3'(MDU_none), 3'(MDU_none), 1'b0);
    assert_reset();
    checks++; if (Busy !== 1'b0) begin errors++;
      $display("FAIL async_reset_busy: got %b expected 0", Busy); end
    checks++; if (ProtoErr !== 1'b0 || StallCnt !== 16'd0) begin errors++;
      $display("FAIL async_reset_regs: got perr=%b scnt=%0d expected 0/0", ProtoErr, StallCnt); end
    release_reset();
    step(1'b0, 1'b1, 3'(MDU_multu), 3'(MDU_none), 1'b0);
    n = 0;
    while (Busy === 1'b1 && n < 20) begin
      n++;
      step(1'b0, 1'b0, 3'(MDU_none), 3'(MDU_none), 1'b0);
    end
    checks++; if (n != 5) begin errors++;
      $display("FAIL post_reset_mult_len: got %0d cycles expected 5", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    step(1'b0, 1'b1, 3'(MDU_div), 3'(MDU_mult), 1'b0);
    n = 0;
    while (Busy === 1'b1 && n < 30) begin
      n++;
      step(1'b0, 1'b0, 3'(MDU_none), 3'(MDU_mult), 1'b0);
    end
    step(1'b0, 1'b1, 3'(MDU_mult), 3'(MDU_none), 1'b1);
    checks++; if (n != 10 || Busy !== 1'b1) begin errors++;
      $display("FAIL back_to_back: got len=%0d busy=%b expected 10/1", n, Busy); end
    n = 0;
    while (Busy === 1'b1 && n < 20) begin
      n++;
      step(1'b0, 1'b0, 3'(MDU_none), 3'(MDU_none), 1'b1);
    end
    step(1'b0, 1'b0, 3'(MDU_none), 3'(MDU_none), 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_mflo();
    test_req_mid_run();
    test_req_issue();
    test_proto_err();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
